xbus_buf: RTL and testbench
===========================

XBUS_BUF -- requirements
Module: xbus_buf

Interface
REQ-001 Parameter REQ_DEPTH, default 4, request FIFO entries (power of 2, >=2).
REQ-002 Parameter MAX_RD, default 4, max outstanding reads (1..15).
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 arst_i  in  1  reset, asynchronous, active-low.
REQ-005 host_req  in  1  request from tile xbus master.
REQ-006 host_we  in  1  1=write, 0=read.
REQ-007 host_addr  in  32  byte address.
REQ-008 host_be  in  4  byte enables.
REQ-009 host_wdata  in  32  write data.
REQ-010 host_ack  out  1  request accepted this cycle.
REQ-011 host_resp  out  1  read data valid, one-cycle pulse.
REQ-012 host_rdata  out  32  read data.
REQ-013 bus_req, bus_we, bus_addr[32], bus_be[4], bus_wdata[32]  out  request toward xbar master port.
REQ-014 bus_ack  in  1; bus_resp  in  1; bus_rdata  in  32: xbar handshake/response.

Function
REQ-015 Transfer on host side SHALL occur only in a cycle with host_req=1 and host_ack=1; fields {we,addr,be,wdata} captured into request FIFO tail.
REQ-016 host_ack SHALL be combinational: host_req & (fifo_cnt < REQ_DEPTH) & (host_we | rd_cnt < MAX_RD).
REQ-017 No full-with-pop passthrough: fifo_cnt = REQ_DEPTH forces host_ack=0 even if a pop occurs same cycle.
REQ-018 bus_req SHALL equal (fifo_cnt != 0); bus_* fields SHALL come from FIFO head, registered; no combinational path host_* -> bus_*.
REQ-019 Minimum request latency: accept in cycle N -> bus_req=1 in cycle N+1.
REQ-020 FIFO head SHALL pop when bus_req & bus_ack; bus_* fields SHALL stay stable while bus_req=1 and bus_ack=0.
REQ-021 Simultaneous push and pop SHALL leave fifo_cnt unchanged; pointers wrap modulo REQ_DEPTH; order strictly preserved.
REQ-022 rd_cnt (4-bit) SHALL increment on accepted read, decrement on bus_resp; both in one cycle -> unchanged.
REQ-023 bus_resp with rd_cnt=0 SHALL NOT underflow rd_cnt; response still forwarded.
REQ-024 Response stage: host_resp(N+1)=bus_resp(N); host_rdata(N+1)=bus_rdata(N) when bus_resp(N)=1, else holds previous value.
REQ-025 Writes SHALL generate no host_resp.
REQ-026 Throughput: one request per cycle sustained when bus_ack=1 continuously and FIFO not full.

Reset
REQ-027 arst_i=0 SHALL immediately clear fifo_cnt, pointers, rd_cnt; bus_req=0, host_resp=0, host_rdata=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
REQ-028 Reset mid-operation SHALL discard queued requests and pending responses; no host_resp for reads issued before reset.
REQ-029 host_ack SHALL be 0 while arst_i=0.
REQ-030 First acceptance possible in first rising edge after arst_i deasserts.

Configuration
REQ-031 Macro XBUS_BUF_STATS_EN SHALL, when defined, add output stall_cnt_o[32]: counts cycles with host_req=1 & host_ack=0, saturating at 0xFFFFFFFF, reset to 0.
REQ-032 Without XBUS_BUF_STATS_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Single read: host read addr 0x100, bus_ack=1, bus_resp 3 cycles later with rdata 0xDEADBEEF -> bus_req one cycle after accept, host_resp one cycle after bus_resp with 0xDEADBEEF, rd_cnt back to 0.
REQ-034 Backpressure: bus_ack=0, 5 back-to-back writes addr 0x0..0x10 -> first 4 acked, 5th held ack=0 until first pop; bus order 0x0,0x4,0x8,0xC,0x10; with STATS_EN stall_cnt_o counts held cycles exactly.
REQ-035 Read credit: 5 reads, bus_ack=1, no bus_resp -> 4 acked, 5th stalls; one bus_resp -> 5th acked next eligible cycle.
REQ-036 Wrap/order: 64 random read/write mix with random bus_ack -> bus sequence equals host sequence exactly, fields unchanged while stalled.
REQ-037 Reset mid-flight: 3 queued requests and 2 outstanding reads, pull arst_i low -> bus_req=0 immediately, later bus_resp does not underflow rd_cnt, no stale host_resp after reset.

Source files
------------

// File: rtl/xbus_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : xbus_buf                                                       |
// | Purpose  : Request FIFO plus read-credit limiter between a tile xbus     |
// |            master and an xbar master port. It also registers the read    |
// |            response. Define XBUS_BUF_STATS_EN to add the stall_cnt_o     |
// |            host-stall counter.                                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module xbus_buf #(
  parameter int REQ_DEPTH = 4,
  parameter int MAX_RD    = 4
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [3:0]  host_be,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic        host_resp,
  output logic [31:0] host_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_resp,
  input  logic [31:0] bus_rdata
`ifdef XBUS_BUF_STATS_EN
  ,output logic [31:0] stall_cnt_o
`endif
);

  localparam int                 c_PTR_W  = $clog2(REQ_DEPTH);
  localparam int                 c_CNT_W  = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(REQ_DEPTH);
  localparam logic [3:0]         c_MAX_RD = 4'(MAX_RD);
  localparam logic [c_PTR_W-1:0] c_PTR_1  = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_1  = c_CNT_W'(1);

  logic               r_we_mem    [REQ_DEPTH];
  logic [31:0]        r_addr_mem  [REQ_DEPTH];
  logic [3:0]         r_be_mem    [REQ_DEPTH];
  logic [31:0]        r_wdata_mem [REQ_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_rd_cnt;
  logic               r_host_resp;
  logic [31:0]        r_host_rdata;

  logic w_push;
  logic w_pop;
  logic w_rd_inc;
  logic w_rd_dec;

  // A full FIFO refuses the host even when the head pops in the same cycle.
  assign host_ack = arst_i & host_req & (r_cnt < c_DEPTH)
                    & (host_we | (r_rd_cnt < c_MAX_RD));

  assign w_push   = host_ack;
  assign w_pop    = bus_req & bus_ack;
  assign w_rd_inc = w_push & ~host_we;
  assign w_rd_dec = bus_resp & (r_rd_cnt != 4'd0);

  // Bus side is driven straight from FIFO storage, so no host_* input reaches it.
  assign bus_req   = (r_cnt != '0);
  assign bus_we    = r_we_mem[r_rd_ptr];
  assign bus_addr  = r_addr_mem[r_rd_ptr];
  assign bus_be    = r_be_mem[r_rd_ptr];
  assign bus_wdata = r_wdata_mem[r_rd_ptr];

  assign host_resp  = r_host_resp;
  assign host_rdata = r_host_rdata;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      for (int i = 0; i < REQ_DEPTH; i++) begin
        r_we_mem[i]    <= 1'b0;
        r_addr_mem[i]  <= 32'd0;
        r_be_mem[i]    <= 4'd0;
        r_wdata_mem[i] <= 32'd0;
      end
    end else if (w_push) begin
      r_we_mem[r_wr_ptr]    <= host_we;
      r_addr_mem[r_wr_ptr]  <= host_addr;
      r_be_mem[r_wr_ptr]    <= host_be;
      r_wdata_mem[r_wr_ptr] <= host_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CNT_1;
        2'b01:   r_cnt <= r_cnt - c_CNT_1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A response arriving with no read outstanding leaves the credit count at zero.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_rd_cnt <= 4'd0;
    end else if (w_rd_inc && !bus_resp) begin
      r_rd_cnt <= r_rd_cnt + 4'd1;
    end else if (!w_rd_inc && w_rd_dec) begin
      r_rd_cnt <= r_rd_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_host_resp  <= 1'b0;
      r_host_rdata <= 32'd0;
    end else begin
      r_host_resp <= bus_resp;
      if (bus_resp) r_host_rdata <= bus_rdata;
    end
  end

`ifdef XBUS_BUF_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_stall_cnt <= 32'd0;
    end else if (host_req && !host_ack && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xbus_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_xbus_buf                                                    |
// | Purpose  : Self-checking bench for xbus_buf (vector tables + scoreboard). |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_xbus_buf;

  localparam int c_D = 4;
  localparam int c_M = 4;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        host_req, host_we;
  logic [31:0] host_addr, host_wdata;
  logic [3:0]  host_be;
  logic        host_ack, host_resp;
  logic [31:0] host_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_resp;
  logic [31:0] bus_rdata;
`ifdef XBUS_BUF_STATS_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] s0;
`endif

  xbus_buf #(.REQ_DEPTH(c_D), .MAX_RD(c_M)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_be(host_be), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_resp(host_resp), .host_rdata(host_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_resp(bus_resp),
    .bus_rdata(bus_rdata)
`ifdef XBUS_BUF_STATS_EN
    ,.stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic        back;
    logic        resp;
    logic [31:0] rdata;
    logic        exp_ack;
  } vec_t;

  req_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state, advanced once per cycle by the monitor.
  int          m_cnt = 0;
  int          m_rd = 0;
  logic        e_resp = 1'b0;
  logic [31:0] e_rdata = 32'd0;
  logic        hold = 1'b0;
  req_t        h_req;
  logic [31:0] m_stall = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk_i) begin
    logic exp_ack;
    logic do_pop;
    req_t got;
    req_t exp_r;
    if (!arst_i) begin
      chk1("rst_bus_req", bus_req, 1'b0);
      chk1("rst_host_ack", host_ack, 1'b0);
      chk1("rst_host_resp", host_resp, 1'b0);
      chk("rst_host_rdata", host_rdata, 32'd0);
      chk("rst_bus_fields", {bus_addr[30:0], bus_we}, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
      sb.delete();
      m_cnt = 0; m_rd = 0; e_resp = 1'b0; e_rdata = 32'd0; hold = 1'b0;
      m_stall = 32'd0;
    end else begin
      exp_ack = host_req && (m_cnt < c_D) && (host_we || (m_rd < c_M));
      chk1("host_ack", host_ack, exp_ack);
      chk1("bus_req", bus_req, m_cnt != 0);
      chk1("host_resp", host_resp, e_resp);
      chk("host_rdata", host_rdata, e_rdata);
`ifdef XBUS_BUF_STATS_EN
      chk("stall_cnt", stall_cnt_o, m_stall);
      if (host_req && !exp_ack && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
      got = {bus_we, bus_addr, bus_be, bus_wdata};
      if (hold) begin
        chk("stable_addr", got.addr, h_req.addr);
        chk("stable_data", got.wdata, h_req.wdata);
        chk("stable_webe", {27'd0, got.we, got.be}, {27'd0, h_req.we, h_req.be});
      end
      do_pop = (m_cnt != 0) && bus_ack;
      if (do_pop) begin
        chk1("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          exp_r = sb.pop_front();
          chk("bus_addr", got.addr, exp_r.addr);
          chk("bus_wdata", got.wdata, exp_r.wdata);
          chk("bus_webe", {27'd0, got.we, got.be}, {27'd0, exp_r.we, exp_r.be});
        end
      end
      hold  = (m_cnt != 0) && !bus_ack;
      h_req = got;
      if (exp_ack) sb.push_back({host_we, host_addr, host_be, host_wdata});
      m_cnt = m_cnt + (exp_ack ? 1 : 0) - (do_pop ? 1 : 0);
      if (exp_ack && !host_we && !bus_resp) m_rd = m_rd + 1;
      else if (!(exp_ack && !host_we) && bus_resp && m_rd > 0) m_rd = m_rd - 1;
      e_resp = bus_resp;
      if (bus_resp) e_rdata = bus_rdata;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input logic req, input logic we, input logic [31:0] addr,
                              input logic back, input logic resp, input logic [31:0] rd,
                              input logic ea);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.back = back;
    v.resp = resp; v.rdata = rd; v.exp_ack = ea;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    host_req = v.req; host_we = v.we; host_addr = v.addr;
    host_be = 4'hF; host_wdata = v.addr ^ 32'hA5A5_0000;
    bus_ack = v.back; bus_resp = v.resp; bus_rdata = v.rdata;
  endtask

  vec_t t1[12];
  vec_t t2[12];

  initial begin
    // Backpressure: four writes fill the FIFO, the fifth waits for a pop.
    t1[0]  = mk(1, 1, 32'h00, 0, 0, 0, 1);
    t1[1]  = mk(1, 1, 32'h04, 0, 0, 0, 1);
    t1[2]  = mk(1, 1, 32'h08, 0, 0, 0, 1);
    t1[3]  = mk(1, 1, 32'h0C, 0, 0, 0, 1);
    t1[4]  = mk(1, 1, 32'h10, 0, 0, 0, 0);
    t1[5]  = mk(1, 1, 32'h10, 0, 0, 0, 0);
    t1[6]  = mk(1, 1, 32'h10, 1, 0, 0, 0);
    t1[7]  = mk(1, 1, 32'h10, 1, 0, 0, 1);
    for (int i = 8; i < 12; i++) t1[i] = mk(0, 0, 32'h0, 1, 0, 0, 0);
    // Read credit: four reads outstanding, fifth waits for one response.
    t2[0]  = mk(1, 0, 32'h20, 1, 0, 0, 1);
    t2[1]  = mk(1, 0, 32'h24, 1, 0, 0, 1);
    t2[2]  = mk(1, 0, 32'h28, 1, 0, 0, 1);
    t2[3]  = mk(1, 0, 32'h2C, 1, 0, 0, 1);
    t2[4]  = mk(1, 0, 32'h30, 1, 0, 0, 0);
    t2[5]  = mk(1, 0, 32'h30, 1, 1, 32'hA5A5_0001, 0);
    t2[6]  = mk(1, 0, 32'h30, 1, 0, 0, 1);
    t2[7]  = mk(0, 0, 32'h0, 1, 1, 32'hA5A5_0002, 0);
    t2[8]  = mk(0, 0, 32'h0, 1, 1, 32'hA5A5_0003, 0);
    t2[9]  = mk(0, 0, 32'h0, 1, 1, 32'hA5A5_0004, 0);
    t2[10] = mk(0, 0, 32'h0, 1, 1, 32'hA5A5_0005, 0);
    t2[11] = mk(0, 0, 32'h0, 1, 0, 0, 0);

    arst_i = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'd0; host_be = 4'd0;
    host_wdata = 32'd0; bus_ack = 1'b0; bus_resp = 1'b0; bus_rdata = 32'd0;
    repeat (3) @(posedge clk_i);
    #1;
    chk1("ack_in_reset", host_ack, 1'b0);
    chk("reset_addr", bus_addr, 32'd0);

    // Single read, accepted on the first edge after reset release.
    arst_i = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h100; host_be = 4'hF; bus_ack = 1'b1;
    #1 chk1("first_ack", host_ack, 1'b1);
    step();
    host_req = 1'b0;
    #1 chk1("rd_bus_req_n1", bus_req, 1'b1);
    chk("rd_bus_addr_n1", bus_addr, 32'h100);
    chk1("rd_bus_we_n1", bus_we, 1'b0);
    step(); step(); step();
    bus_resp = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_resp = 1'b0; bus_rdata = 32'h0;
    chk1("rd_host_resp", host_resp, 1'b1);
    chk("rd_host_rdata", host_rdata, 32'hDEAD_BEEF);
    step();
    chk1("rd_resp_pulse", host_resp, 1'b0);
    chk("rd_rdata_hold", host_rdata, 32'hDEAD_BEEF);

`ifdef XBUS_BUF_STATS_EN
    s0 = stall_cnt_o;
`endif
    for (int i = 0; i < 12; i++) begin
      apply(t1[i]);
      #1 chk1("t1_ack", host_ack, t1[i].exp_ack);
      step();
    end
`ifdef XBUS_BUF_STATS_EN
    chk("t1_stall_delta", stall_cnt_o - s0, 32'd3);
`endif
    for (int i = 0; i < 12; i++) begin
      apply(t2[i]);
      #1 chk1("t2_ack", host_ack, t2[i].exp_ack);
      step();
    end

    // Reset with three queued writes and two reads outstanding.
    apply(mk(1, 0, 32'h40, 1, 0, 0, 1)); step();
    apply(mk(1, 0, 32'h44, 1, 0, 0, 1)); step();
    apply(mk(1, 0, 32'h48, 1, 0, 0, 1)); step();
    apply(mk(0, 0, 32'h0, 1, 0, 0, 0)); step();
    apply(mk(1, 1, 32'h50, 0, 0, 0, 1)); step();
    apply(mk(1, 1, 32'h54, 0, 0, 0, 1)); step();
    apply(mk(1, 1, 32'h58, 0, 0, 0, 1)); step();
    apply(mk(0, 0, 32'h0, 0, 1, 32'h1111_2222, 0)); step();
    bus_resp = 1'b0;
    chk1("pre_rst_bus_req", bus_req, 1'b1);
    #2 arst_i = 1'b0;
    host_req = 1'b1;
    #1 chk1("async_bus_req", bus_req, 1'b0);
    chk1("async_host_resp", host_resp, 1'b0);
    chk("async_host_rdata", host_rdata, 32'd0);
    chk("async_bus_addr", bus_addr, 32'd0);
    step(); step();
    arst_i = 1'b1;
    host_req = 1'b0; bus_resp = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    step(); step();
    bus_resp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(mk(1, 0, 32'h60 + 32'(4 * i), 1, 0, 0, 0));
      #1 chk1("credit_after_rst", host_ack, i < 4);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      apply(mk(0, 0, 32'h0, 1, i < 4, 32'h7700_0000 + 32'(i), 0));
      step();
    end

    // Random mix with random bus backpressure.
    for (int i = 0; i < 64; i++) begin
      host_req   = ($urandom_range(0, 3) != 0);
      host_we    = $urandom_range(0, 1) == 1;
      host_addr  = $urandom() & 32'hFFFF_FFFC;
      host_be    = 4'($urandom_range(0, 15));
      host_wdata = $urandom();
      bus_ack    = $urandom_range(0, 2) != 0;
      bus_resp   = (m_rd > 0) && ($urandom_range(0, 1) == 1);
      bus_rdata  = $urandom();
      step();
    end
    for (int i = 0; i < 40 && (m_cnt != 0 || m_rd != 0); i++) begin
      host_req = 1'b0; bus_ack = 1'b1; bus_resp = (m_rd > 0); bus_rdata = 32'hC0DE_0000 + 32'(i);
      step();
    end
    bus_resp = 1'b0;
    step();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_rd_done", 32'(m_rd), 32'd0);
    chk1("drain_bus_req", bus_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
